// File: rtl/dsd_master_mc.sv
// Multichannel DSD serialiser: collects 16-bit payload beats into one word per channel,
// then shifts every channel out on the falling edge of the DSD bit clock.
module dsd_master_mc #(
  parameter int NCH       = 2,
  parameter int WORD_W    = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic           sck_in,
  input  logic           rst_n,
  input  logic           start_n,
  input  logic           stop_n,
  input  logic           dop,
  input  logic [15:0]    in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           clr_underrun,
  output logic [NCH-1:0] ch_out,
  output logic           sck_out,
  output logic           busy,
  output logic           underrun
);

  localparam int BUF_W = NCH * WORD_W;
  localparam int PW    = $clog2(BUF_W);
  localparam int CW    = $clog2(NCH);
  localparam int BW    = $clog2(WORD_W / 8);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [WORD_W-1:0] SILENCE     = {(WORD_W / 8){8'h69}};
  localparam logic [BUF_W-1:0]  SILENCE_ALL = {NCH{SILENCE}};

  typedef enum logic [1:0] {IDLE, PRIME, XFER} state_t;

  state_t           r_state;
  logic             r_dop;
  logic             r_full;
  logic             r_underrun;
  logic [CW-1:0]    r_chIdx;
  logic [BW-1:0]    r_beatIdx;
  logic [CNT_W-1:0] r_bitCnt;
  logic [BUF_W-1:0] r_buf;
  logic [BUF_W-1:0] r_shift;

  logic [BUF_W-1:0] w_shiftNext;
  logic [PW-1:0]    w_bitPos;
  logic [7:0]       w_dopByte;
  logic             w_accept;
  logic             w_lastBeat;
  logic             w_lastCh;
  logic             w_boundary;
  logic             w_setUnder;

  assign busy     = (r_state != IDLE);
  assign in_ready = busy & ~r_full;
  assign underrun = r_underrun;
  assign sck_out  = (r_state == XFER) ? sck_in : 1'b1;

  assign w_accept   = in_valid & in_ready;
  assign w_lastBeat = (r_beatIdx == (r_dop ? BW'(WORD_W / 8 - 1) : BW'(WORD_W / 16 - 1)));
  assign w_lastCh   = (r_chIdx == CW'(NCH - 1));
  assign w_boundary = (r_bitCnt == CNT_W'(WORD_W - 1));
  assign w_setUnder = (r_state == XFER) & w_boundary & stop_n & ~r_full;
  assign w_dopByte  = r_beatIdx[0] ? in_data[7:0] : in_data[15:8];

  // Beats are stored channel-major; DoP carries one byte per beat, native a full half-word.
  always_comb begin
    w_bitPos = PW'(r_chIdx) * PW'(WORD_W) + PW'(r_beatIdx) * (r_dop ? PW'(8) : PW'(16));
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_shiftNext[c*WORD_W +: WORD_W] = {1'b0, r_shift[c*WORD_W+1 +: WORD_W-1]};
      assign ch_out[c] = r_shift[c*WORD_W];
    end else begin : g_msb
      assign w_shiftNext[c*WORD_W +: WORD_W] = {r_shift[c*WORD_W +: WORD_W-1], 1'b0};
      assign ch_out[c] = r_shift[c*WORD_W+WORD_W-1];
    end
  end

  always_ff @(negedge sck_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dop      <= 1'b0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_chIdx    <= '0;
      r_beatIdx  <= '0;
      r_bitCnt   <= '0;
      r_buf      <= '0;
      r_shift    <= SILENCE_ALL;
    end else begin
      if (w_setUnder) begin
        r_underrun <= 1'b1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
      end

      if (w_accept) begin
        if (r_dop) begin
          r_buf[w_bitPos +: 8] <= w_dopByte;
        end else begin
          r_buf[w_bitPos +: 16] <= in_data;
        end
        if (w_lastBeat) begin
          r_beatIdx <= '0;
          if (w_lastCh) begin
            r_chIdx <= '0;
            r_full  <= 1'b1;
          end else begin
            r_chIdx <= r_chIdx + CW'(1);
          end
        end else begin
          r_beatIdx <= r_beatIdx + BW'(1);
        end
      end

      case (r_state)
        IDLE: begin
          r_buf     <= '0;
          r_full    <= 1'b0;
          r_chIdx   <= '0;
          r_beatIdx <= '0;
          r_bitCnt  <= '0;
          r_shift   <= SILENCE_ALL;
          if (!start_n) begin
            r_state <= PRIME;
            r_dop   <= dop;
          end
        end
        PRIME: begin
          if (!stop_n) begin
            r_state <= IDLE;
          end else if (r_full) begin
            r_shift  <= r_buf;
            r_buf    <= '0;
            r_full   <= 1'b0;
            r_bitCnt <= '0;
            r_state  <= XFER;
          end
        end
        XFER: begin
          r_bitCnt <= r_bitCnt + CNT_W'(1);
          // Fullness is judged on the pre-edge state, so a beat landing on this edge waits a word.
          if (w_boundary) begin
            if (!stop_n) begin
              r_shift <= SILENCE_ALL;
              r_state <= IDLE;
            end else if (r_full) begin
              r_shift <= r_buf;
              r_buf   <= '0;
              r_full  <= 1'b0;
            end else begin
              r_shift <= SILENCE_ALL;
            end
          end else begin
            r_shift <= w_shiftNext;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dsd_master_mc.md
DSD_MASTER_MC -- requirements
Module: dsd_master_mc

Interface
REQ-001 SHALL have parameter NCH, default 2: output channel count, even, 2..8.
REQ-002 SHALL have parameter WORD_W, default 32: bits per channel word, one of 16/32/64.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = bit WORD_W-1 first.
REQ-004 SHALL have port sck_in, input, 1: DSD bit clock; all registers update on its falling edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start_n, input, 1: active-low stream start request.
REQ-007 SHALL have port stop_n, input, 1: active-low stream stop request.
REQ-008 SHALL have port dop, input, 1: 1 = DoP byte packing, 0 = native 16-bit packing.
REQ-009 SHALL have port in_data, input, 16: payload beat.
REQ-010 SHALL have port in_valid, input, 1: in_data is valid.
REQ-011 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-012 SHALL have port clr_underrun, input, 1: clears the underrun flag.
REQ-013 SHALL have port ch_out, output, NCH: serial DSD data, one bit per channel.
REQ-014 SHALL have port sck_out, output, 1: gated bit clock.
REQ-015 SHALL have port busy, output, 1: high in states PRIME and XFER.
REQ-016 SHALL have port underrun, output, 1: sticky underrun flag.

Function
REQ-017 SHALL implement states IDLE, PRIME, XFER; mode (dop) latched on IDLE->PRIME and ignored elsewhere.
REQ-018 IDLE: start_n low -> PRIME; load buffer and beat counter cleared every IDLE cycle.
REQ-019 A beat SHALL be accepted on an edge with in_valid & in_ready; in_ready = busy & load buffer not full.
REQ-020 Native mode: BPC = WORD_W/16 beats per channel, each filling 16 bits of the word, low half first, channel-major order (ch0 all beats, then ch1, ...).
REQ-021 DoP mode: BPC = WORD_W/8 beats per channel; payload byte = in_data[15:8] on even beat index within the channel, in_data[7:0] on odd; bytes fill low to high.
REQ-022 Buffer full when NCH*BPC beats have been accepted; no beat accepted while full.
REQ-023 PRIME: sck_out held 1, ch_out = silence bit; buffer full -> copy buffer into shift registers, clear buffer, bit_cnt=0, -> XFER.
REQ-024 XFER: sck_out = sck_in; each edge shifts every channel register one bit in LSB_FIRST order; bit_cnt increments and wraps at WORD_W-1.
REQ-025 Word boundary (edge with bit_cnt = WORD_W-1): if buffer full (pre-edge state), load it into shift registers and clear it; else load silence pattern 0x69 repeated to WORD_W and set underrun.
REQ-026 A beat completing the buffer on a boundary edge SHALL NOT be used at that boundary (underrun) and is kept for the next boundary.
REQ-027 stop_n low sampled on a boundary edge -> IDLE after that edge; stop_n elsewhere ignored until next boundary.
REQ-028 start_n in PRIME/XFER ignored; stop_n in PRIME -> IDLE immediately.
REQ-029 underrun SHALL stay set until clr_underrun sampled high; a set and clear on the same edge leaves it set.
REQ-030 Outside XFER, ch_out SHALL present the silence pattern's current bit held static.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, bit_cnt=0, buffer cleared, shift registers = silence pattern, underrun=0, in_ready=0, busy=0, sck_out=1.
REQ-032 Reset mid-XFER SHALL discard buffered and in-flight data; no partial word emitted after release.

Verification
REQ-033 NCH=2, WORD_W=32, native: start, 4 beats 0x1111,0x2222,0x3333,0x4444 -> ch0 serialises 0x22221111, ch1 0x44443333 LSB first, sck_out toggles 32 edges per word.
REQ-034 DoP, NCH=2: 8 beats 0xA5xx,0xxx5A,... -> ch0 word low bytes 0xA5,0x5A in order; odd/even byte selection verified.
REQ-035 Withhold beats after first word -> second word = 0x69696969 on all channels, underrun=1, persists until clr_underrun pulse.
REQ-036 Buffer completes on a boundary edge -> silence word plus underrun, buffered data emitted at next boundary.
REQ-037 stop_n asserted mid-word -> word completes, then sck_out=1, busy=0, in_ready=0.
REQ-038 rst_n low mid-XFER -> immediate IDLE, sck_out=1, restart sends fresh data only.
